id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register and operand-forwarding unit directly upstream of the ALU.
//  Captures decoded fields, selects the ALU's a/b/op and store data with EX/MEM and
//  MEM/WB forwarding, and detects the load-use hazard (stall + bubble). Branch flush from EX kills the captured instr.
// PARAMETERS
//  DSIZE  16  datapath width; must equal `DSIZE from define.v
//  ASIZE  3   register-address width; register 0 reads as zero, never forwarded
// PORTS
//  clk            in   1      clock, all state updates on posedge
//  rst            in   1      synchronous reset, active high
//  id_valid       in   1      decode slot holds a real instruction
//  id_op          in   4      ALU opcode (`ADD..`BEQ)
//  id_rs1_addr    in   ASIZE  source 1 register address
//  id_rs2_addr    in   ASIZE  source 2 register address
//  id_rs1_used    in   1      instr reads rs1
//  id_rs2_used    in   1      instr reads rs2 (incl. SW store data, BEQ compare)
//  id_rs1_data    in   DSIZE  register-file read data, port 1
//  id_rs2_data    in   DSIZE  register-file read data, port 2
//  id_imm         in   DSIZE  sign-extended immediate
//  id_use_imm     in   1      alu_b takes immediate instead of rs2
//  id_rd_addr     in   ASIZE  destination register
//  id_wen         in   1      instr writes rd
//  id_is_load     in   1      instr is LW
//  flush          in   1      branch taken in EX: kill instr entering EX
//  exm_rd/exm_wen/exm_is_load  in ASIZE/1/1  EX/MEM stage dest info
//  exm_result     in   DSIZE  EX/MEM ALU result
//  wb_rd/wb_wen   in   ASIZE/1  MEM/WB dest info
//  wb_data        in   DSIZE  MEM/WB write-back value
//  stall          out  1      hold PC and IF/ID this cycle (combinational)
//  alu_a/alu_b    out  DSIZE  ALU operands (forwarded)
//  alu_op         out  4      ALU opcode
//  ex_store_data  out  DSIZE  forwarded rs2 for SW
//  ex_imm         out  DSIZE  registered immediate (branch offset)
//  ex_rd/ex_wen/ex_is_load/ex_valid  out ASIZE/1/1/1  fields passed to EX/MEM
// BEHAVIOUR
//  - Reset: all ex_* regs, alu_op=4'b0000, ex_valid=0 -> alu_a=alu_b=ex_store_data=0, stall=0.
//  - Latency 1: fields present at ID on edge N drive ALU inputs during cycle N+1.
//  - Capture write-through: if wb_wen & wb_rd!=0 & wb_rd==id_rsX_addr, capture wb_data, not id_rsX_data.
//  - Hazard: haz = id_valid & ex_valid & ex_is_load & ex_wen & ex_rd!=0 &
//    ((id_rs1_used & id_rs1_addr==ex_rd) | (id_rs2_used & id_rs2_addr==ex_rd)); stall = haz & !flush.
//  - Edge priority flush > haz > advance. flush or haz: load bubble (ex_valid=0, ex_wen=0,
//    ex_is_load=0, op=4'b0000, data regs 0). Else capture ID fields; ex_valid=id_valid, ex_wen=id_wen&id_valid.
//  - Upstream holds ID fields while stall=1; re-evaluated next cycle, load then in MEM/WB.
//  - Forward src X (combinational, from registered ex_rsX): priority
//    (1) exm_wen & !exm_is_load & exm_rd!=0 & exm_rd==ex_rsX -> exm_result;
//    (2) wb_wen & wb_rd!=0 & wb_rd==ex_rsX -> wb_data; (3) registered data.
//  - alu_a=fwd1; alu_b = ex_use_imm ? ex_imm : fwd2; ex_store_data=fwd2 always.
//  - Address 0 never forwarded, never triggers stall. No arithmetic; widths pass through unchanged.
//  - Reset mid-stall: stall drops the cycle after reset edge; in-flight EX instr discarded.
// TESTING
//  1 rst high 2 cycles -> ex_valid=0, alu_a=alu_b=0, stall=0; release, ADD r1,r2(5),r3(7) -> alu_a=5,alu_b=7 next cycle.
//  2 ADD r1=12 in EX/MEM, SUB r4,r1,r2(3) in EX -> alu_a=12 via exm_result; r1 also in MEM/WB=9 -> still 12.
//  3 LW r2 in EX, ADD r5,r2,r3 in ID -> stall=1 one cycle, bubble in EX; next cycle alu_a=wb_data(0x00AA).
//  4 LW r2 in EX, flush=1, dependent instr in ID -> stall=0, bubble captured, ex_valid=0 next cycle.
//  5 ID reads r3 while wb_wen=1,wb_rd=3,wb_data=0x1234, rf shows 0 -> captured/alu value 0x1234.
//  6 ADD r0 writes 5, next instr reads r0 -> no forward, alu_a=0; SW with imm=4: alu_b=4, ex_store_data=fwd rs2.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding into the ALU and load-use hazard detection.
// A taken branch (flush) or a load-use hazard turns the instruction entering EX into a bubble.
module id_ex_operand_stage #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_op,
  input  logic [ASIZE-1:0] id_rs1_addr,
  input  logic [ASIZE-1:0] id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [DSIZE-1:0] id_rs1_data,
  input  logic [DSIZE-1:0] id_rs2_data,
  input  logic [DSIZE-1:0] id_imm,
  input  logic             id_use_imm,
  input  logic [ASIZE-1:0] id_rd_addr,
  input  logic             id_wen,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic [ASIZE-1:0] exm_rd,
  input  logic             exm_wen,
  input  logic             exm_is_load,
  input  logic [DSIZE-1:0] exm_result,
  input  logic [ASIZE-1:0] wb_rd,
  input  logic             wb_wen,
  input  logic [DSIZE-1:0] wb_data,
  output logic             stall,
  output logic [DSIZE-1:0] alu_a,
  output logic [DSIZE-1:0] alu_b,
  output logic [3:0]       alu_op,
  output logic [DSIZE-1:0] ex_store_data,
  output logic [DSIZE-1:0] ex_imm,
  output logic [ASIZE-1:0] ex_rd,
  output logic             ex_wen,
  output logic             ex_is_load,
  output logic             ex_valid
);

  logic [ASIZE-1:0] ex_rs1;
  logic [ASIZE-1:0] ex_rs2;
  logic [DSIZE-1:0] ex_rs1_data;
  logic [DSIZE-1:0] ex_rs2_data;
  logic             ex_use_imm;
  logic             haz;
  logic             bubble;
  logic [DSIZE-1:0] cap1;
  logic [DSIZE-1:0] cap2;
  logic [DSIZE-1:0] fwd1;
  logic [DSIZE-1:0] fwd2;

  // Newest producer wins; register 0 is hard-wired to zero and is never a match.
  function automatic logic [DSIZE-1:0] pick(
    input logic [ASIZE-1:0] rs,
    input logic [DSIZE-1:0] regval,
    input logic             near_ok,
    input logic [ASIZE-1:0] near_rd,
    input logic [DSIZE-1:0] near_val,
    input logic             far_ok,
    input logic [ASIZE-1:0] far_rd,
    input logic [DSIZE-1:0] far_val
  );
    if (rs == '0)                        return regval;
    else if (near_ok && near_rd == rs)   return near_val;
    else if (far_ok && far_rd == rs)     return far_val;
    else                                 return regval;
  endfunction

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    haz = 1'b0;
    if (id_valid && ex_valid && ex_is_load && ex_wen && ex_rd != '0) begin
      haz = (id_rs1_used && id_rs1_addr == ex_rd) ||
            (id_rs2_used && id_rs2_addr == ex_rd);
    end
  end

  assign stall  = haz && !flush;
  assign bubble = flush || haz;

  // Write-through: a value being written back this cycle is newer than the register-file read.
  assign cap1 = pick(id_rs1_addr, id_rs1_data, 1'b0, '0, '0, wb_wen, wb_rd, wb_data);
  assign cap2 = pick(id_rs2_addr, id_rs2_data, 1'b0, '0, '0, wb_wen, wb_rd, wb_data);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ex_valid    <= 1'b0;
      ex_wen      <= 1'b0;
      ex_is_load  <= 1'b0;
      alu_op      <= 4'b0000;
      ex_rd       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_use_imm  <= 1'b0;
    end else begin
      ex_valid    <= id_valid;
      ex_wen      <= id_wen && id_valid;
      ex_is_load  <= id_is_load;
      alu_op      <= id_op;
      ex_rd       <= id_rd_addr;
      ex_rs1      <= id_rs1_addr;
      ex_rs2      <= id_rs2_addr;
      ex_rs1_data <= cap1;
      ex_rs2_data <= cap2;
      ex_imm      <= id_imm;
      ex_use_imm  <= id_use_imm;
    end
  end

  // A load in EX/MEM has no data yet; its consumer was already held back by the stall.
  assign fwd1 = pick(ex_rs1, ex_rs1_data, exm_wen && !exm_is_load, exm_rd, exm_result,
                     wb_wen, wb_rd, wb_data);
  assign fwd2 = pick(ex_rs2, ex_rs2_data, exm_wen && !exm_is_load, exm_rd, exm_result,
                     wb_wen, wb_rd, wb_data);

  assign alu_a         = fwd1;
  assign alu_b         = ex_use_imm ? ex_imm : fwd2;
  assign ex_store_data = fwd2;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed pipeline scenarios plus randomized cycles,
// all checked every cycle against a transaction-level model of the instruction sitting in EX.
module tb_id_ex_operand_stage;

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd8;
  localparam logic [3:0] OP_SW  = 4'd9;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rs1_used, id_rs2_used, id_use_imm, id_wen, id_is_load, flush;
  logic [3:0]  id_op;
  logic [2:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, exm_rd, wb_rd;
  logic [15:0] id_rs1_data, id_rs2_data, id_imm, exm_result, wb_data;
  logic        exm_wen, exm_is_load, wb_wen;
  logic        stall, ex_wen, ex_is_load, ex_valid;
  logic [15:0] alu_a, alu_b, ex_store_data, ex_imm;
  logic [3:0]  alu_op;
  logic [2:0]  ex_rd;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic [2:0]  rs1, rs2, rd;
    logic [15:0] d1, d2, imm;
    logic        use_imm, wen, ld;
  } ex_t;

  ex_t m;
  logic last_stall;

  id_ex_operand_stage #(.DSIZE(16), .ASIZE(3)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_op(id_op),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm),
    .id_rd_addr(id_rd_addr), .id_wen(id_wen), .id_is_load(id_is_load),
    .flush(flush),
    .exm_rd(exm_rd), .exm_wen(exm_wen), .exm_is_load(exm_is_load), .exm_result(exm_result),
    .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_data(wb_data),
    .stall(stall), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .ex_store_data(ex_store_data), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_valid(ex_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Value an EX operand should see: the youngest non-load writer of that register.
  function automatic logic [15:0] exp_operand(input logic [2:0] r, input logic [15:0] held);
    if (r == 3'd0) return held;
    if (exm_wen && !exm_is_load && exm_rd == r) return exm_result;
    if (wb_wen && wb_rd == r) return wb_data;
    return held;
  endfunction

  function automatic logic exp_hazard();
    logic reads;
    reads = (id_rs1_used && id_rs1_addr == m.rd) || (id_rs2_used && id_rs2_addr == m.rd);
    return id_valid && m.valid && m.ld && m.wen && (m.rd != 3'd0) && reads;
  endfunction

  function automatic logic [15:0] fresh(input logic [2:0] a, input logic [15:0] rf);
    return (wb_wen && a != 3'd0 && wb_rd == a) ? wb_data : rf;
  endfunction

  // Check every output against the model mid-cycle, then advance one clock edge.
  task automatic tick();
    ex_t nx;
    logic h;
    logic [15:0] b2;
    @(negedge clk);
    h  = exp_hazard();
    b2 = exp_operand(m.rs2, m.d2);
    check("stall",      stall,         h && !flush);
    check("ex_valid",   ex_valid,      m.valid);
    check("ex_wen",     ex_wen,        m.wen);
    check("ex_is_load", ex_is_load,    m.ld);
    check("ex_rd",      ex_rd,         m.rd);
    check("alu_op",     alu_op,        m.op);
    check("ex_imm",     ex_imm,        m.imm);
    check("alu_a",      alu_a,         exp_operand(m.rs1, m.d1));
    check("alu_b",      alu_b,         m.use_imm ? m.imm : b2);
    check("store",      ex_store_data, b2);
    last_stall = h && !flush;
    nx = '{valid: 1'b0, op: 4'd0, rs1: 3'd0, rs2: 3'd0, rd: 3'd0, d1: 16'd0, d2: 16'd0,
           imm: 16'd0, use_imm: 1'b0, wen: 1'b0, ld: 1'b0};
    if (!rst && !flush && !h) begin
      nx = '{valid: id_valid, op: id_op, rs1: id_rs1_addr, rs2: id_rs2_addr, rd: id_rd_addr,
             d1: fresh(id_rs1_addr, id_rs1_data), d2: fresh(id_rs2_addr, id_rs2_data),
             imm: id_imm, use_imm: id_use_imm, wen: id_wen && id_valid, ld: id_is_load};
    end
    @(posedge clk);
    #1;
    m = nx;
  endtask

  task automatic set_id(input logic v, input logic [3:0] op,
                        input logic [2:0] rs1, input logic u1, input logic [15:0] d1,
                        input logic [2:0] rs2, input logic u2, input logic [15:0] d2,
                        input logic [15:0] imm, input logic ui,
                        input logic [2:0] rd, input logic wen, input logic ld);
    id_valid = v; id_op = op;
    id_rs1_addr = rs1; id_rs1_used = u1; id_rs1_data = d1;
    id_rs2_addr = rs2; id_rs2_used = u2; id_rs2_data = d2;
    id_imm = imm; id_use_imm = ui; id_rd_addr = rd; id_wen = wen; id_is_load = ld;
  endtask

  task automatic set_fw(input logic [2:0] erd, input logic ewen, input logic eld,
                        input logic [15:0] eres,
                        input logic [2:0] wrd, input logic wwen, input logic [15:0] wdat);
    exm_rd = erd; exm_wen = ewen; exm_is_load = eld; exm_result = eres;
    wb_rd = wrd; wb_wen = wwen; wb_data = wdat;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    set_id(0, 4'd0, 3'd0, 0, 16'd0, 3'd0, 0, 16'd0, 16'd0, 0, 3'd0, 0, 0);
    set_fw(3'd0, 0, 0, 16'd0, 3'd0, 0, 16'd0);
    m = '{valid: 1'b0, op: 4'd0, rs1: 3'd0, rs2: 3'd0, rd: 3'd0, d1: 16'd0, d2: 16'd0,
          imm: 16'd0, use_imm: 1'b0, wen: 1'b0, ld: 1'b0};
    last_stall = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", ex_valid, 0);
    check("rst_a",     alu_a,    0);
    check("rst_b",     alu_b,    0);
    check("rst_stall", stall,    0);
    check("rst_op",    alu_op,   0);

    // ADD r1, r2(5), r3(7)
    rst = 1'b0;
    set_id(1, OP_ADD, 3'd2, 1, 16'd5, 3'd3, 1, 16'd7, 16'd0, 0, 3'd1, 1, 0);
    tick();
    #1;
    check("t1_a", alu_a, 16'd5);
    check("t1_b", alu_b, 16'd7);

    // SUB r4, r1, r2: r1 forwarded from EX/MEM, which beats MEM/WB
    set_id(1, OP_SUB, 3'd1, 1, 16'd0, 3'd2, 1, 16'd3, 16'd0, 0, 3'd4, 1, 0);
    tick();
    set_fw(3'd1, 1, 0, 16'd12, 3'd0, 0, 16'd0);
    #1;
    check("t2_exm", alu_a, 16'd12);
    check("t2_b",   alu_b, 16'd3);
    set_fw(3'd1, 1, 0, 16'd12, 3'd1, 1, 16'd9);
    #1;
    check("t2_prio", alu_a, 16'd12);
    set_fw(3'd1, 0, 0, 16'd12, 3'd1, 1, 16'd9);
    #1;
    check("t2_wb", alu_a, 16'd9);

    // LW r2 then dependent ADD r5, r2, r3: one stall, then MEM/WB forward
    set_fw(3'd0, 0, 0, 16'd0, 3'd0, 0, 16'd0);
    set_id(1, OP_LW, 3'd3, 1, 16'd0, 3'd0, 0, 16'd0, 16'd0, 1, 3'd2, 1, 1);
    tick();
    set_id(1, OP_ADD, 3'd2, 1, 16'd0, 3'd3, 1, 16'd7, 16'd0, 0, 3'd5, 1, 0);
    #1;
    check("t3_stall", stall, 1);
    tick();
    set_fw(3'd2, 1, 1, 16'h0040, 3'd0, 0, 16'd0);
    #1;
    check("t3_bubble",  ex_valid, 0);
    check("t3_unstall", stall,    0);
    tick();
    set_fw(3'd0, 0, 0, 16'd0, 3'd2, 1, 16'h00AA);
    #1;
    check("t3_fwd", alu_a, 16'h00AA);

    // Flush beats the load-use hazard
    set_fw(3'd0, 0, 0, 16'd0, 3'd0, 0, 16'd0);
    set_id(1, OP_LW, 3'd3, 1, 16'd0, 3'd0, 0, 16'd0, 16'd0, 1, 3'd2, 1, 1);
    tick();
    set_id(1, OP_ADD, 3'd2, 1, 16'd0, 3'd3, 1, 16'd7, 16'd0, 0, 3'd5, 1, 0);
    flush = 1'b1;
    #1;
    check("t4_stall", stall, 0);
    tick();
    flush = 1'b0;
    #1;
    check("t4_valid", ex_valid, 0);
    check("t4_op",    alu_op,   0);

    // Write-through on capture
    set_id(1, OP_ADD, 3'd3, 1, 16'd0, 3'd0, 0, 16'd0, 16'd0, 0, 3'd6, 1, 0);
    set_fw(3'd0, 0, 0, 16'd0, 3'd3, 1, 16'h1234);
    tick();
    set_fw(3'd0, 0, 0, 16'd0, 3'd0, 0, 16'd0);
    #1;
    check("t5_wt", alu_a, 16'h1234);

    // r0 never forwarded; SW uses immediate for alu_b and forwarded rs2 for store data
    set_id(1, OP_ADD, 3'd0, 1, 16'd0, 3'd0, 1, 16'd0, 16'd0, 0, 3'd6, 1, 0);
    set_fw(3'd0, 1, 0, 16'd5, 3'd0, 1, 16'd5);
    tick();
    #1;
    check("t6_r0", alu_a, 16'd0);
    set_id(1, OP_SW, 3'd1, 1, 16'h0010, 3'd3, 1, 16'h0077, 16'd4, 1, 3'd0, 0, 0);
    set_fw(3'd0, 0, 0, 16'd0, 3'd0, 0, 16'd0);
    tick();
    set_fw(3'd3, 1, 0, 16'h0099, 3'd0, 0, 16'd0);
    #1;
    check("t6_b",     alu_b,         16'd4);
    check("t6_store", ex_store_data, 16'h0099);

    // Reset while stalled: stall drops after the reset edge
    set_fw(3'd0, 0, 0, 16'd0, 3'd0, 0, 16'd0);
    set_id(1, OP_LW, 3'd3, 1, 16'd0, 3'd0, 0, 16'd0, 16'd0, 1, 3'd2, 1, 1);
    tick();
    set_id(1, OP_ADD, 3'd2, 1, 16'd0, 3'd3, 1, 16'd7, 16'd0, 0, 3'd5, 1, 0);
    rst = 1'b1;
    #1;
    check("t7_stall", stall, 1);
    tick();
    rst = 1'b0;
    #1;
    check("t7_drop",  stall,    0);
    check("t7_valid", ex_valid, 0);

    // Randomized cycles; small register space so hazards and forwards are frequent
    for (int i = 0; i < 500; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 7) == 0);
      if (!last_stall) begin
        set_id($urandom_range(0, 7) != 0, 4'($urandom),
               3'($urandom_range(0, 3)), 1'($urandom), 16'($urandom),
               3'($urandom_range(0, 3)), 1'($urandom), 16'($urandom),
               16'($urandom), 1'($urandom),
               3'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 2) == 0));
      end
      set_fw(3'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 16'($urandom),
             3'($urandom_range(0, 3)), 1'($urandom), 16'($urandom));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
